ext_seg_adder: RTL and testbench

Parametrised, pipelined successor to the fixed-width zero-extend-and-add block. It adds a wide operand A (WA bits) to a narrow operand B (WB bits), zero-extended and optionally left-shifted, producing a WA+1-bit sum. The carry chain is split into SEG-bit segments with one register stage per segment, under a valid/ready handshake. An accumulate mode replaces A with an internal accumulator, so a stream of B values can be summed.

---
 rtl/ext_seg_adder_pkg.sv | 14 +
 rtl/adder_segment.sv | 23 ++
 rtl/ext_seg_adder.sv | 176 +++++++++++++++++
 tb/tb_ext_seg_adder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_seg_adder_pkg.sv
// Shared constants for ext_seg_adder: default operand, segment and shift widths,
// plus the ceil-div helper used to size the pipeline.
package ext_seg_adder_pkg;

  localparam int unsigned WA_DEF  = 61;
  localparam int unsigned WB_DEF  = 11;
  localparam int unsigned SEG_DEF = 16;
  localparam int unsigned SHW_DEF = 6;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One slice of the segmented carry chain: W-bit add with carry-in and carry-out.
// Ports:
//   i_a, i_b  W-bit operand slices
//   i_cin     carry from the previous segment
//   o_sum     W-bit slice sum
//   o_cout    carry into the next segment
module adder_segment #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];

endmodule

// File: rtl/ext_seg_adder.sv
// Pipelined zero-extend-shift-and-add with an optional internal accumulator.
// A (WA bits, or the accumulator) plus (zero-extended B << shift) gives a WA+1-bit sum.
// The carry chain is cut into SEG-bit segments, one register stage per segment.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               input handshake
//   in_a, in_b, in_shift            operands and left shift for B
//   in_acc, in_clr                  accumulate mode / restart accumulator at 0
//   out_valid/out_ready             output handshake
//   out_sum, out_trunc              result (MSB = carry-out), B bits lost to the shift
//   acc_ovf                         sticky carry-out of accumulate ops
module ext_seg_adder
  import ext_seg_adder_pkg::*;
#(
  parameter int unsigned WA  = WA_DEF,
  parameter int unsigned WB  = WB_DEF,
  parameter int unsigned SEG = SEG_DEF,
  parameter int unsigned SHW = SHW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] in_a,
  input  logic [WB-1:0] in_b,
  input  logic [SHW-1:0] in_shift,
  input  logic          in_acc,
  input  logic          in_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA:0]   out_sum,
  output logic          out_trunc,
  output logic          acc_ovf
);

  localparam int unsigned NSEG = ceil_div(WA, SEG);
  // Wide enough that no B bit is lost for any shift amount, so truncation is visible.
  localparam int unsigned WX   = WA + (2 ** SHW);

  // Index k holds the register stage k+1: sum bits finished up to the end of segment k,
  // untouched A bits above, the full shifted B and the carry out of segment k.
  logic          r_vld   [NSEG];
  logic          r_accop [NSEG];
  logic          r_clr   [NSEG];
  logic          r_trunc [NSEG];
  logic          r_cy    [NSEG];
  logic [WA-1:0] r_s     [NSEG];
  logic [WA-1:0] r_b     [NSEG];
  logic [WA-1:0] r_acc;
  logic          r_ovf;

  logic          w_load    [NSEG];
  logic          w_accin   [NSEG];
  logic          w_clrin   [NSEG];
  logic          w_truncin [NSEG];
  logic          w_cy_nxt  [NSEG];
  logic [WA-1:0] w_s_nxt   [NSEG];
  logic [WA-1:0] w_b_nxt   [NSEG];

  logic [WX-1:0] w_ext;
  logic [WA-1:0] w_op2;
  logic [WA-1:0] w_a;
  logic          w_trunc;
  logic          w_advance;
  logic          w_pending;
  logic          w_accept;

  assign w_ext   = WX'(in_b) << in_shift;
  assign w_op2   = w_ext[WA-1:0];
  assign w_trunc = |w_ext[WX-1:WA];

  always_comb begin
    w_a = in_a;
    if (in_acc) begin
      w_a = in_clr ? '0 : r_acc;
    end
  end

  // An accumulate op must see the accumulator written by its predecessor, which
  // happens as that predecessor enters the last stage.
  always_comb begin
    w_pending = 1'b0;
    for (int k = 0; k < NSEG - 1; k++) begin
      w_pending = w_pending | (r_vld[k] & r_accop[k]);
    end
  end

  assign w_advance = !r_vld[NSEG-1] || out_ready;
  assign in_ready  = rst_n && w_advance && !(in_acc && w_pending);
  assign w_accept  = in_valid && in_ready;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int unsigned SegLo = k * SEG;
    localparam int unsigned SegHi = (SegLo + SEG > WA) ? WA : SegLo + SEG;
    localparam int unsigned SegW  = SegHi - SegLo;
    localparam logic [WA-1:0] SegMask = ((WA'(1) << SegHi) - WA'(1)) &
                                        ~((WA'(1) << SegLo) - WA'(1));

    logic [WA-1:0]   w_a_src;
    logic [WA-1:0]   w_b_src;
    logic            w_cin;
    logic [SegW-1:0] w_sum;
    logic            w_cout;

    if (k == 0) begin : g_first
      assign w_a_src      = w_a;
      assign w_b_src      = w_op2;
      assign w_cin        = 1'b0;
      assign w_load[k]    = w_accept;
      assign w_accin[k]   = in_acc;
      assign w_clrin[k]   = in_clr;
      assign w_truncin[k] = w_trunc;
    end else begin : g_rest
      assign w_a_src      = r_s[k-1];
      assign w_b_src      = r_b[k-1];
      assign w_cin        = r_cy[k-1];
      assign w_load[k]    = r_vld[k-1];
      assign w_accin[k]   = r_accop[k-1];
      assign w_clrin[k]   = r_clr[k-1];
      assign w_truncin[k] = r_trunc[k-1];
    end

    adder_segment #(
      .W (SegW)
    ) u_seg (
      .i_a    (w_a_src[SegHi-1:SegLo]),
      .i_b    (w_b_src[SegHi-1:SegLo]),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
    );

    assign w_s_nxt[k]  = (w_a_src & ~SegMask) | (WA'(w_sum) << SegLo);
    assign w_b_nxt[k]  = w_b_src;
    assign w_cy_nxt[k] = w_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        r_vld[k]   <= 1'b0;
        r_accop[k] <= 1'b0;
        r_clr[k]   <= 1'b0;
        r_trunc[k] <= 1'b0;
        r_cy[k]    <= 1'b0;
        r_s[k]     <= '0;
        r_b[k]     <= '0;
      end
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < NSEG; k++) begin
        r_vld[k] <= w_load[k];
        // Payload only moves with a valid op, so bubbles leave the last result in place.
        if (w_load[k]) begin
          r_accop[k] <= w_accin[k];
          r_clr[k]   <= w_clrin[k];
          r_trunc[k] <= w_truncin[k];
          r_cy[k]    <= w_cy_nxt[k];
          r_s[k]     <= w_s_nxt[k];
          r_b[k]     <= w_b_nxt[k];
        end
      end
      if (w_load[NSEG-1] && w_accin[NSEG-1]) begin
        r_acc <= w_s_nxt[NSEG-1];
        r_ovf <= (r_ovf & ~w_clrin[NSEG-1]) | w_cy_nxt[NSEG-1];
      end
    end
  end

  assign out_valid = r_vld[NSEG-1];
  assign out_sum   = {r_cy[NSEG-1], r_s[NSEG-1]};
  assign out_trunc = r_trunc[NSEG-1];
  assign acc_ovf   = r_ovf;

endmodule

// File: tb/tb_ext_seg_adder.sv
module tb_ext_seg_adder;

  localparam int NSEG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [60:0] in_a;
  logic [10:0] in_b;
  logic [5:0]  in_shift;
  logic        in_acc;
  logic        in_clr;
  logic        out_valid;
  logic        out_ready;
  logic [61:0] out_sum;
  logic        out_trunc;
  logic        acc_ovf;

  always #5 clk = ~clk;

  ext_seg_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_shift  (in_shift),
    .in_acc    (in_acc),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_trunc (out_trunc),
    .acc_ovf   (acc_ovf)
  );

  typedef struct {
    logic [61:0] sum;
    logic        trunc;
    bit          is_acc;
    logic        ovf;
    bit          chk_lat;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [60:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic        held_v = 1'b0;
  logic [61:0] held_sum;
  logic        held_tr;
  bit          rnd_on;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic on the accepted operation.
  task automatic model_push(input logic [60:0] a, input logic [10:0] b, input logic [5:0] sh,
                            input logic acc, input logic clr, input bit lat, input int c);
    logic [127:0] full;
    logic [60:0]  op2;
    logic [60:0]  aa;
    exp_t         e;
    full = 128'(b) << sh;
    op2  = full[60:0];
    aa   = acc ? (clr ? 61'd0 : m_acc) : a;
    e.sum     = {1'b0, aa} + {1'b0, op2};
    e.trunc   = |full[127:61];
    e.is_acc  = acc;
    e.chk_lat = lat;
    e.cyc     = c;
    if (acc) begin
      m_acc = e.sum[60:0];
      m_ovf = (clr ? 1'b0 : m_ovf) | e.sum[61];
    end
    e.ovf = m_ovf;
    q.push_back(e);
  endtask

  task automatic send(input logic [60:0] a, input logic [10:0] b, input logic [5:0] sh,
                      input logic acc, input logic clr, input bit lat, output int acyc);
    bit done;
    done     = 1'b0;
    acyc     = -1;
    in_a     = a;
    in_b     = b;
    in_shift = sh;
    in_acc   = acc;
    in_clr   = clr;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acyc = cyc;
        model_push(a, b, sh, acc, clr, lat, cyc);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: checks every delivered result against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (out_valid && held_v) begin
        chk("hold_sum", 64'(out_sum), 64'(held_sum));
        chk("hold_trunc", 64'(out_trunc), 64'(held_tr));
      end
      if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %h required no output", out_sum);
        end else begin
          e_mon = q.pop_front();
          chk("sum", 64'(out_sum), 64'(e_mon.sum));
          chk("trunc", 64'(out_trunc), 64'(e_mon.trunc));
          if (e_mon.is_acc) chk("acc_ovf", 64'(acc_ovf), 64'(e_mon.ovf));
          if (e_mon.chk_lat) chk("latency", 64'(cyc - e_mon.cyc), 64'(NSEG));
        end
      end
      held_v   = out_valid && !out_ready;
      held_sum = out_sum;
      held_tr  = out_trunc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, dummy;
    logic [63:0] r64;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_shift  = '0;
    in_acc    = 1'b0;
    in_clr    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_trunc", 64'(out_trunc), 64'd0);
    chk("rst_acc_ovf", 64'(acc_ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    send(61'h1FFF_FFFF_FFFF_FFFF, 11'd1, 6'd0, 1'b0, 1'b0, 1'b1, dummy);
    drain();
    send(61'h123_4567_89AB_CDEF, 11'h7FF, 6'd0, 1'b0, 1'b0, 1'b1, dummy);
    drain();
    send(61'd0, 11'h7FF, 6'd55, 1'b0, 1'b0, 1'b1, dummy);
    drain();

    // Accumulate chain with in_valid held
    send(61'd0, 11'd5, 6'd0, 1'b1, 1'b1, 1'b1, c1);
    send(61'd0, 11'd7, 6'd0, 1'b1, 1'b0, 1'b1, c2);
    send(61'd0, 11'd9, 6'd0, 1'b1, 1'b0, 1'b1, c3);
    chk("acc_spacing1", 64'(c2 - c1), 64'(NSEG));
    chk("acc_spacing2", 64'(c3 - c2), 64'(NSEG));
    drain();

    // Fill the accumulator with ones, then overflow it
    send(61'd0, 11'h7FF, 6'd0,  1'b1, 1'b1, 1'b0, dummy);
    send(61'd0, 11'h7FF, 6'd11, 1'b1, 1'b0, 1'b0, dummy);
    send(61'd0, 11'h7FF, 6'd22, 1'b1, 1'b0, 1'b0, dummy);
    send(61'd0, 11'h7FF, 6'd33, 1'b1, 1'b0, 1'b0, dummy);
    send(61'd0, 11'h7FF, 6'd44, 1'b1, 1'b0, 1'b0, dummy);
    send(61'd0, 11'h03F, 6'd55, 1'b1, 1'b0, 1'b0, dummy);
    send(61'd0, 11'd1, 6'd0, 1'b1, 1'b0, 1'b0, dummy);
    send(61'd0, 11'd2, 6'd0, 1'b1, 1'b0, 1'b0, dummy);
    send(61'h55, 11'd3, 6'd1, 1'b0, 1'b0, 1'b0, dummy);
    drain();
    chk("acc_ovf_sticky", 64'(acc_ovf), 64'(m_ovf));

    // Backpressure: six back-to-back ops with a 4-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          r64 = {$urandom(), $urandom()};
          send(r64[60:0], 11'($urandom()), 6'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b0, dummy);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("ovf_before_rst", 64'(acc_ovf), 64'(m_ovf));

    // Reset with three ops in flight
    send(61'h1111, 11'd1, 6'd0, 1'b0, 1'b0, 1'b0, dummy);
    send(61'h2222, 11'd2, 6'd0, 1'b0, 1'b0, 1'b0, dummy);
    send(61'h3333, 11'd3, 6'd0, 1'b0, 1'b0, 1'b0, dummy);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_acc_ovf", 64'(acc_ovf), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    q.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(61'h0ABC_DEF0_1234, 11'h123, 6'd7, 1'b0, 1'b0, 1'b1, dummy);
    send(61'd0, 11'd3, 6'd0, 1'b1, 1'b0, 1'b0, dummy);
    drain();

    // Randomized mix with random downstream stalls
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic acc;
          r64 = {$urandom(), $urandom()};
          acc = ($urandom_range(0, 3) == 0);
          send(r64[60:0], 11'($urandom()), 6'($urandom_range(0, 63)), acc,
               acc && ($urandom_range(0, 3) == 0), 1'b0, dummy);
          if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("final_acc_ovf", 64'(acc_ovf), 64'(m_ovf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
